// File: rtl/mdu_if.sv
// mdu_if: E-stage multiply/divide unit bus.
//   op    : operation code from the E stage (0 NONE, 1 MULT, 2 MULTU,
//           3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7-15 NONE)
//   a, b  : forwarded rs / rt operands
//   busy  : a multiply/divide is in flight (feeds D-stage stall logic)
//   start : combinational accept indication for op 1-4 while idle
//   hi/lo : architectural HI / LO registers
// master = pipeline side, slave = MDU side.
`timescale 1ns/1ps
interface mdu_if;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output op, a, b, input busy, start, hi, lo);
    modport slave  (input op, a, b, output busy, start, hi, lo);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit with HI/LO registers.
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : mdu_if.slave (op, a, b in; busy, start, hi, lo out)
// The 64-bit result is computed at the accepting edge into shadow
// registers and committed to HI/LO only after the busy countdown, so
// the visible latency matches the modelled pipeline latency.
`timescale 1ns/1ps
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      state_r, state_nxt_s;
    logic [3:0]  cnt_r, cnt_nxt_s;
    logic [31:0] hs_r, ls_r, hi_r, lo_r;
    logic        div0_r;
    logic        start_s, commit_s, is_div_s;
    logic [63:0] res_s;

    // Unsigned divide returning {remainder, quotient}; zero divisor yields 0
    // (the result is discarded in that case anyway).
    function automatic logic [63:0] div_u(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] q;
        logic [31:0] r;
        if (d == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = n / d;
            r = n % d;
        end
        return {r, q};
    endfunction

    // Signed divide via magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to
    // 0x80000000 with remainder 0 naturally through the unsigned path.
    function automatic logic [63:0] div_s(input logic [31:0] n, input logic [31:0] d);
        logic [31:0] un, ud, uq, ur;
        logic [63:0] u;
        un = n[31] ? (32'd0 - n) : n;
        ud = d[31] ? (32'd0 - d) : d;
        u  = div_u(un, ud);
        uq = u[31:0];
        ur = u[63:32];
        return {(n[31] ? (32'd0 - ur) : ur), ((n[31] ^ d[31]) ? (32'd0 - uq) : uq)};
    endfunction

    // Result datapath for the operation presented this cycle.
    always_comb begin
        res_s = 64'd0;
        case (bus.op)
            OP_MULT:  res_s = 64'($signed(bus.a)) * 64'($signed(bus.b));
            OP_MULTU: res_s = {32'd0, bus.a} * {32'd0, bus.b};
            OP_DIV:   res_s = div_s(bus.a, bus.b);
            OP_DIVU:  res_s = div_u(bus.a, bus.b);
            default:  res_s = 64'd0;
        endcase
    end

    // Next-state logic: accept in IDLE, count down in BUSY, commit on cnt==1.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        start_s     = 1'b0;
        commit_s    = 1'b0;
        is_div_s    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        case (state_r)
            ST_IDLE: begin
                if ((bus.op >= OP_MULT) && (bus.op <= OP_DIVU)) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = is_div_s ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // <= guards against a zero count ever stranding the FSM in BUSY.
                if (cnt_r <= 4'd1) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, shadow and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            hs_r    <= 32'd0;
            ls_r    <= 32'd0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            div0_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (start_s) begin
                hs_r   <= res_s[63:32];
                ls_r   <= res_s[31:0];
                div0_r <= is_div_s && (bus.b == 32'd0);
            end
            if (commit_s && !div0_r) begin
                hi_r <= hs_r;
                lo_r <= ls_r;
            end
            if (state_r == ST_IDLE) begin
                if (bus.op == OP_MTHI) hi_r <= bus.a;
                if (bus.op == OP_MTLO) lo_r <= bus.a;
            end
        end
    end

    assign bus.busy  = (state_r == ST_BUSY);
    assign bus.start = start_s;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table-driven check of the mdu plus hand-written sequences for
// the ignored-op-while-busy and reset-mid-operation cases.
`timescale 1ns/1ps
module tb_mdu;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mdu_if bus ();
    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Present one op, check start, then count busy cycles (bounded) and check HI/LO.
    task automatic run_vec(input int idx, input vec_t v);
        int n;
        @(negedge clk);
        bus.op = v.op;
        bus.a  = v.a;
        bus.b  = v.b;
        #1;
        chk($sformatf("start[%0d]", idx), {31'd0, bus.start}, {31'd0, (v.cyc > 0)});
        @(posedge clk);
        #1;
        bus.op = 4'd0;
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk($sformatf("cycles[%0d]", idx), 32'(n), 32'(v.cyc));
        chk($sformatf("hi[%0d]", idx), bus.hi, v.hi);
        chk($sformatf("lo[%0d]", idx), bus.lo, v.lo);
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003,  5, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{4'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
        vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{4'd5, 32'h12345678, 32'h00000000,  0, 32'h12345678, 32'h80000000};
        vecs[6]  = '{4'd4, 32'h00000009, 32'h00000000, 10, 32'h12345678, 32'h80000000};
        vecs[7]  = '{4'd6, 32'h0000DEAD, 32'h00000000,  0, 32'h12345678, 32'h0000DEAD};
        vecs[8]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF,  5, 32'h3FFFFFFF, 32'h00000001};
        vecs[10] = '{4'd9, 32'hAAAAAAAA, 32'h55555555,  0, 32'h3FFFFFFF, 32'h00000001};
        vecs[11] = '{4'd2, 32'h00010000, 32'h00010000,  5, 32'h00000001, 32'h00000000};

        reset  = 1'b1;
        bus.op = 4'd0;
        bus.a  = 32'd0;
        bus.b  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy",  {31'd0, bus.busy},  32'd0);
        chk("rst_start", {31'd0, bus.start}, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Ops presented while busy must be ignored; start stays low.
        @(negedge clk);
        bus.op = 4'd1; bus.a = 32'h00010001; bus.b = 32'h00010000;
        @(posedge clk); #1;                          // accept, busy cycle 1
        bus.op = 4'd0;
        @(posedge clk); #1;                          // busy cycle 2
        bus.op = 4'd1; bus.a = 32'd7; bus.b = 32'd7;
        #1;
        chk("busy_start", {31'd0, bus.start}, 32'd0);
        @(posedge clk); #1;                          // busy cycle 3
        bus.op = 4'd6; bus.a = 32'h0000DEAD;
        @(posedge clk); #1;
        bus.op = 4'd0;
        chk("busy_lo_hold", bus.lo, 32'h00000000);
        repeat (2) @(posedge clk);
        #1;
        chk("ign_busy", {31'd0, bus.busy}, 32'd0);
        chk("ign_hi", bus.hi, 32'h00000001);
        chk("ign_lo", bus.lo, 32'h00010000);

        // Reset in busy cycle 2 abandons the result.
        @(negedge clk);
        bus.op = 4'd1; bus.a = 32'd3; bus.b = 32'd5;
        @(posedge clk); #1;                          // busy cycle 1
        bus.op = 4'd0;
        chk("rb_busy1", {31'd0, bus.busy}, 32'd1);
        @(posedge clk); #1;                          // busy cycle 2
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rb_busy", {31'd0, bus.busy}, 32'd0);
        chk("rb_hi", bus.hi, 32'd0);
        chk("rb_lo", bus.lo, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("rb_late_busy", {31'd0, bus.busy}, 32'd0);
        chk("rb_late_hi", bus.hi, 32'd0);
        chk("rb_late_lo", bus.lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration in cycles for MULT/MULTU, legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration in cycles for DIV/DIVU, legal range 1..15.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset; clock clk.
REQ-005 op  input  4  E-stage MDU operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7-15 treated as NONE.
REQ-006 a  input  32  rs operand (forwarded value).
REQ-007 b  input  32  rt operand (forwarded value).
REQ-008 busy  output  1  high while a MULT/MULTU/DIV/DIVU is in flight; consumed by D-stage stall logic.
REQ-009 start  output  1  combinational; high when op is 1-4 and state is IDLE.
REQ-010 hi  output  32  architectural HI register.
REQ-011 lo  output  32  architectural LO register.

Function
REQ-012 The block SHALL hold a two-state FSM: IDLE, BUSY, plus a 4-bit down-counter cnt.
REQ-013 In IDLE with op 1-4 at a posedge, the block SHALL compute the 64-bit result from a,b, latch it in shadow registers hs/ls, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-014 busy SHALL equal (state==BUSY); it is first high in the cycle after the accepting edge.
REQ-015 In BUSY, cnt SHALL decrement each edge; on the edge where cnt==1, hi<=hs, lo<=ls, state<=IDLE.
REQ-016 busy SHALL therefore be high for exactly MULT_CYCLES or DIV_CYCLES cycles; new hi/lo visible in the first cycle busy is low.
REQ-017 MULT: {hs,ls} = $signed(a)*$signed(b), 64-bit two's complement; MULTU: unsigned 64-bit product.
REQ-018 DIV: ls = signed quotient truncated toward zero, hs = remainder with sign of dividend; DIVU: unsigned quotient/remainder.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give ls=0x80000000, hs=0x00000000.
REQ-020 DIV/DIVU with b==0 SHALL still run the full DIV_CYCLES busy period and SHALL leave hi and lo unchanged.
REQ-021 MTHI/MTLO in IDLE SHALL write a to hi/lo respectively at that edge; no busy period.
REQ-022 Any op 1-6 presented while BUSY SHALL be ignored (stall logic guarantees it does not occur; block must not corrupt state if it does).
REQ-023 hi and lo SHALL change only via REQ-015 or REQ-021.
REQ-024 start SHALL be 0 while BUSY regardless of op.

Reset
REQ-025 reset at a posedge SHALL set state=IDLE, cnt=0, hs=ls=0, hi=0, lo=0, busy=0, overriding any op.
REQ-026 reset mid-operation SHALL abandon the in-flight result; hi/lo read 0 afterwards, no late commit.

Verification
REQ-027 MULT a=0xFFFFFFFE(-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-028 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-029 DIV a=0xFFFFFFF9(-7), b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
REQ-030 MTHI a=0x12345678 then DIVU b=0 -> busy 10 cycles; hi stays 0x12345678, lo unchanged.
REQ-031 MULT accepted, MTLO a=0xDEAD presented during cycle 3 of busy -> ignored; lo equals product low word after commit.
REQ-032 MULT accepted, reset asserted in busy cycle 2 -> next cycle busy=0, hi=lo=0; no commit on later edges.
